// File: rtl/lms_ctr_pkt_pkg.sv
// Shared types and constants for the host/CPU control packet bridge.
package lms_ctr_pkt_pkg;
    localparam int DEF_DW        = 32;
    localparam int DEF_PKT_WORDS = 16;
    localparam int DEF_CMD_PKTS  = 2;
    localparam int DEF_CMD_AW    = $clog2(DEF_CMD_PKTS * DEF_PKT_WORDS);
    localparam int DEF_PKT_AW    = $clog2(DEF_PKT_WORDS);

    localparam int ERR_RD_EMPTY = 0;
    localparam int ERR_WR_FULL  = 1;

    typedef enum logic {FILL = 1'b0, SEND = 1'b1} tx_state_e;
endpackage

// File: rtl/lms_ctr_pkt_ram.sv
// Simple dual-port RAM with registered read; read register clears on reset/clr.
module lms_ctr_pkt_ram
    import lms_ctr_pkt_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_PKT_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  rdata <= '0;
        else if (clr)  rdata <= '0;
        else if (re)   rdata <= mem[raddr];
    end
endmodule

// File: rtl/lms_ctr_pkt_bridge.sv
// Host<->CPU control packet bridge: store-and-forward command FIFO toward the
// CPU, single-packet reply buffer toward the host.
module lms_ctr_pkt_bridge
    import lms_ctr_pkt_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int PKT_WORDS = DEF_PKT_WORDS,
    parameter int CMD_PKTS  = DEF_CMD_PKTS
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] h_rx_data,
    input  logic          h_rx_valid,
    output logic          h_rx_ready,
    output logic [DW-1:0] h_tx_data,
    output logic          h_tx_valid,
    input  logic          h_tx_ready,
    output logic [DW-1:0] if_d,
    input  logic          if_rd,
    output logic          if_rdempty,
    input  logic [DW-1:0] of_d,
    input  logic          of_wr,
    output logic          of_wrfull,
    input  logic          soft_rst,
    output logic [1:0]    err_flags
);
    localparam int D   = CMD_PKTS * PKT_WORDS;
    localparam int CAW = $clog2(D);
    localparam int RAW = $clog2(PKT_WORDS);

    logic [CAW:0]   wp, cp, rp;
    logic [RAW-1:0] rxc, wcnt, tcnt;
    logic           rdy_q, full, rx_acc, rd_ok;
    logic           err_rd, err_wr;
    tx_state_e      state;
    logic           tx_vld, tx_last, tx_re;
    logic [RAW-1:0] tx_raddr;

    // ---------------- command path ----------------
    assign full       = (wp - rp) == (CAW+1)'(D);
    assign h_rx_ready = rdy_q && !full;
    assign if_rdempty = (cp == rp);
    assign rx_acc     = h_rx_valid && h_rx_ready;
    assign rd_ok      = if_rd && !if_rdempty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp     <= '0;
            cp     <= '0;
            rp     <= '0;
            rxc    <= '0;
            rdy_q  <= 1'b0;
            err_rd <= 1'b0;
        end else if (soft_rst) begin
            wp     <= '0;
            cp     <= '0;
            rp     <= '0;
            rxc    <= '0;
            rdy_q  <= 1'b0;
            err_rd <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (rx_acc) begin
                wp  <= wp + 1'b1;
                rxc <= rxc + 1'b1;
                // Publish the packet in the same edge its last word lands
                if (rxc == RAW'(PKT_WORDS-1)) cp <= wp + 1'b1;
            end
            if (rd_ok) rp <= rp + 1'b1;
            if (if_rd && if_rdempty) err_rd <= 1'b1;
        end
    end

    lms_ctr_pkt_ram #(.DW(DW), .AW(CAW)) u_cmd_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (soft_rst),
        .we     (rx_acc && !soft_rst),
        .waddr  (wp[CAW-1:0]),
        .wdata  (h_rx_data),
        .re     (rd_ok && !soft_rst),
        .raddr  (rp[CAW-1:0]),
        .rdata  (if_d)
    );

    // ---------------- reply path ----------------
    assign tx_last   = (tcnt == RAW'(PKT_WORDS-1));
    // First SEND cycle loads word 0; afterwards each accepted beat prefetches the next
    assign tx_re     = (state == SEND) && (!tx_vld || (h_tx_ready && !tx_last));
    assign tx_raddr  = tx_vld ? tcnt + RAW'(1) : tcnt;
    assign h_tx_valid = tx_vld;
    assign of_wrfull  = (state == SEND);
    assign err_flags  = {err_wr, err_rd};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FILL;
            wcnt   <= '0;
            tcnt   <= '0;
            tx_vld <= 1'b0;
            err_wr <= 1'b0;
        end else if (soft_rst) begin
            state  <= FILL;
            wcnt   <= '0;
            tcnt   <= '0;
            tx_vld <= 1'b0;
            err_wr <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (of_wr) begin
                        wcnt <= wcnt + RAW'(1);
                        if (wcnt == RAW'(PKT_WORDS-1)) state <= SEND;
                    end
                end
                SEND: begin
                    if (of_wr) err_wr <= 1'b1;
                    if (!tx_vld) begin
                        tx_vld <= 1'b1;
                    end else if (h_tx_ready) begin
                        if (tx_last) begin
                            state  <= FILL;
                            tx_vld <= 1'b0;
                            tcnt   <= '0;
                            wcnt   <= '0;
                        end else begin
                            tcnt <= tcnt + RAW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    lms_ctr_pkt_ram #(.DW(DW), .AW(RAW)) u_reply_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (soft_rst),
        .we     (of_wr && (state == FILL) && !soft_rst),
        .waddr  (wcnt),
        .wdata  (of_d),
        .re     (tx_re && !soft_rst),
        .raddr  (tx_raddr),
        .rdata  (h_tx_data)
    );
endmodule

// File: doc/lms_ctr_pkt_bridge.md
Name: lms_ctr_pkt_bridge

Overview:
- Packet bridge between the host control-endpoint stream and the control CPU's 32-bit external FIFO ports: if-side read port, of-side write port, soft reset.
- Host-to-CPU: store-and-forward command buffer. It exposes only complete 16-word control packets to the CPU read port.
- CPU-to-host: single-packet reply buffer. It collects one full reply packet from the CPU write port, then streams it to the host with valid/ready.

Parameters:
- DW, 32, data word width (host and CPU sides).
- PKT_WORDS, 16, words per control packet (64-byte packet); power of two.
- CMD_PKTS, 2, command buffer depth in packets; power of two; total depth CMD_PKTS*PKT_WORDS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- h_rx_data  in  DW  host command word.
- h_rx_valid  in  1  host command word valid.
- h_rx_ready  out  1  bridge can accept a command word.
- h_tx_data  out  DW  reply word to host.
- h_tx_valid  out  1  reply word valid.
- h_tx_ready  in  1  host accepts reply word.
- if_d  out  DW  command word to CPU; registered.
- if_rd  in  1  CPU read strobe.
- if_rdempty  out  1  no committed command word available.
- of_d  in  DW  reply word from CPU.
- of_wr  in  1  CPU write strobe.
- of_wrfull  out  1  reply buffer cannot accept writes.
- soft_rst  in  1  synchronous flush request from CPU, active high.
- err_flags  out  2  sticky errors: [0] rd while empty, [1] wr while full; cleared by soft_rst.

Behaviour:
- Reset (reset_n=0, asynchronous) and soft_rst=1 (synchronous, takes effect next edge) both force:
  - all pointers and counters to 0, and the TX state machine to FILL;
  - h_rx_ready=0 for the reset cycle, then 1;
  - h_tx_valid=0, h_tx_data=0, if_d=0, if_rdempty=1, of_wrfull=0, err_flags=0.
- soft_rst has priority over every simultaneous event. Words accepted in its cycle are discarded.
- Command buffer: circular RAM of depth D=CMD_PKTS*PKT_WORDS, with write pointer wp, commit pointer cp and read pointer rp.
  - Pointers are log2(D)+1 bits with wrap bit; full when wp-rp == D.
  - h_rx_ready = !full. A word is written when h_rx_valid && h_rx_ready, and wp increments.
  - A rx word counter counts 0..PKT_WORDS-1. When the last word is accepted, cp := wp+1 in the same edge as that write.
  - if_rdempty = (cp == rp). Partial packets are never visible to the CPU.
  - if_rd && !if_rdempty: rp increments and if_d is updated on the same edge. Data is valid the cycle after the strobe (normal-mode FIFO, no show-ahead).
  - if_rd && if_rdempty: ignored; if_d holds; err_flags[0] set.
  - Simultaneous write, commit and read are all legal in one cycle. Full and empty are computed from the registered pointers.
- Reply buffer: PKT_WORDS-entry RAM with a 2-state machine.
  - FILL:
    - of_wrfull=0 and h_tx_valid=0.
    - of_wr writes of_d at wcnt, and wcnt increments.
    - On the write with wcnt==PKT_WORDS-1, go to SEND; of_wrfull=1 from the next cycle.
  - SEND:
    - of_wrfull=1. h_tx_valid=1 with h_tx_data=buf[tcnt]; output registered, first word one cycle after entering SEND.
    - On h_tx_valid && h_tx_ready, tcnt increments and the next word is presented the following cycle; no bubble is required but one is permitted.
    - After the last word is accepted, go to FILL. tcnt and wcnt := 0; h_tx_valid=0 and of_wrfull=0 next cycle.
    - of_wr in SEND is ignored and sets err_flags[1].
  - h_tx_data is stable while h_tx_valid && !h_tx_ready.
- Counter and pointer arithmetic is unsigned modulo width; no saturation is needed.

Decomposition:
- Package lms_ctr_pkt_pkg holds:
  - localparams for pointer widths (clog2 of depths);
  - the TX state enum {FILL, SEND};
  - error-bit index constants.
- One sub-module, lms_ctr_pkt_ram: simple dual-port RAM (DW x depth, registered read). Instantiated twice: command buffer and reply buffer.

Test Plan:
- Command commit: push 15 words 0x100..0x10E -> if_rdempty stays 1. Push 16th word 0x10F -> if_rdempty=0 the cycle after acceptance. 16 if_rd strobes -> if_d = 0x100..0x10F, each one cycle after its strobe. if_rdempty=1 after the 16th read.
- Backpressure: push 32 words with no CPU reads (CMD_PKTS=2) -> h_rx_ready=0 after word 32. One if_rd -> h_rx_ready=1 the next cycle.
- Empty read: if_rd with if_rdempty=1 -> if_d unchanged, err_flags=2'b01.
- Reply path: CPU writes 0xA0..0xAF -> of_wrfull=1 after the 16th write. With h_tx_ready toggled 1/0 every cycle, 16 host beats = 0xA0..0xAF in order, data held while stalled. of_wrfull=0 after the last beat.
- Write while full: of_wr during SEND -> no effect on h_tx_data, err_flags[1]=1.
- Soft reset mid-operation: 7 command words pushed and 5 reply words written, then soft_rst pulse -> if_rdempty=1, of_wrfull=0, h_tx_valid=0, err_flags=0. A new 16-word command is then received intact from its first word.
